// File: rtl/fetch_line_buffer.sv
// Fetch front end: streams 64-byte bus lines into a 128-byte byte ring and
// presents a 15-byte decode window to the decoder, with redirect/flush.
module fetch_line_buffer #(
  parameter int BUF_BYTES  = 128,
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 8,
  parameter int WIN_BYTES  = 15,
  parameter int TAG_W      = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            entry,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_rip,
  output logic                   bus_reqcyc,
  output logic [63:0]            bus_req,
  output logic [TAG_W-1:0]       bus_reqtag,
  input  logic                   bus_reqack,
  input  logic                   bus_respcyc,
  input  logic [63:0]            bus_resp,
  output logic                   bus_respack,
  output logic [8*WIN_BYTES-1:0] win_bytes,
  output logic [3:0]             win_count,
  input  logic [3:0]             consume,
  output logic [7:0]             occupancy
);

  localparam int AW = $clog2(BUF_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RECV  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic       READ   = 1'b1;
  localparam logic [3:0] MEMORY = 4'b0001;

  logic [1:0]    state;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [7:0]    occ;
  logic [63:0]   fetch_rip;
  logic [5:0]    skip;
  logic [2:0]    beat_idx;
  logic          reqcyc;
  logic [7:0]    mem [BUF_BYTES];

  logic          beat_live;
  logic [2:0]    first;
  logic [3:0]    nwr;
  logic [3:0]    cons;
  logic [7:0]    occ_next;

  assign bus_reqcyc  = reqcyc;
  assign bus_req     = fetch_rip;
  assign bus_reqtag  = TAG_W'({READ, MEMORY, 8'h00});
  assign bus_respack = bus_respcyc;
  assign occupancy   = occ;
  assign win_count   = (occ > 8'(WIN_BYTES)) ? 4'(WIN_BYTES) : occ[3:0];

  assign beat_live = bus_respcyc && (state == S_WAIT || state == S_RECV);

  // Beats before the skip beat write nothing; the skip beat drops its low bytes.
  always_comb begin
    first = (beat_idx == skip[5:3]) ? skip[2:0] : 3'd0;
    nwr   = 4'd0;
    if (beat_live && !redirect_valid && beat_idx >= skip[5:3])
      nwr = 4'(BEAT_BYTES) - {1'b0, first};
    cons  = (consume <= win_count) ? consume : 4'd0;
  end

  assign occ_next = occ + 8'(nwr) - 8'(cons);

  for (genvar i = 0; i < WIN_BYTES; i++) begin : g_win
    logic [AW-1:0] idx;
    assign idx = head + AW'(i);
    assign win_bytes[8*i +: 8] = (4'(i) < win_count) ? mem[idx] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!reset && nwr != 4'd0) begin
      for (int k = 0; k < BEAT_BYTES; k++) begin
        if (k >= int'(first))
          mem[tail + AW'(k - int'(first))] <= bus_resp[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      reqcyc    <= 1'b0;
      beat_idx  <= '0;
      fetch_rip <= {entry[63:6], 6'b0};
      skip      <= entry[5:0];
    end else if (redirect_valid) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      reqcyc    <= 1'b0;
      fetch_rip <= {redirect_rip[63:6], 6'b0};
      skip      <= redirect_rip[5:0];
      unique case (state)
        S_IDLE: begin
          if (reqcyc && bus_reqack) begin
            state    <= S_DRAIN;
            beat_idx <= '0;
          end
        end
        default: begin
          // A beat landing with the redirect still counts toward the drain.
          state <= S_DRAIN;
          if (bus_respcyc) begin
            beat_idx <= beat_idx + 3'd1;
            if (beat_idx == 3'd7) state <= S_IDLE;
          end
        end
      endcase
    end else begin
      head <= head + AW'(cons);
      tail <= tail + AW'(nwr);
      occ  <= occ_next;
      unique case (state)
        S_IDLE: begin
          if (reqcyc) begin
            if (bus_reqack) begin
              reqcyc   <= 1'b0;
              state    <= S_WAIT;
              beat_idx <= '0;
            end
          end else if (occ <= 8'(BUF_BYTES - LINE_BYTES)) begin
            reqcyc <= 1'b1;
          end
        end
        S_WAIT, S_RECV: begin
          if (bus_respcyc) begin
            beat_idx <= beat_idx + 3'd1;
            state    <= S_RECV;
            if (beat_idx == 3'd7) begin
              state     <= S_IDLE;
              fetch_rip <= fetch_rip + 64'(LINE_BYTES);
              skip      <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (bus_respcyc) begin
            beat_idx <= beat_idx + 3'd1;
            if (beat_idx == 3'd7) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus_respcyc && state == S_IDLE))
        else $fatal(1, "response beat while idle");
      assert (redirect_valid || consume <= win_count)
        else $fatal(1, "consume exceeds window");
    end
  end

endmodule
